// File: rtl/result_mon_pkg.sv
// rtl/result_mon_pkg.sv - shared defaults, entry record and drop-counter limit for the result monitor
package result_mon_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_TS_W   = 16;

    localparam logic [7:0] DROP_MAX = 8'd255;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic [DEF_TS_W-1:0]   stamp;
    } entry_t;

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - synchronous FIFO of captured entries, head read straight from storage
module result_fifo
    import result_mon_pkg::*;
#(
    parameter int  DEPTH  = DEF_DEPTH,
    parameter type item_t = entry_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  item_t                  push_item,
    input  logic                   pop,
    output logic [$clog2(DEPTH):0] level,
    output item_t                  head
);

    localparam int AW = $clog2(DEPTH);

    item_t         mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    // Storage is reset so the head reads as zero whenever the FIFO is empty after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_item;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/result_monitor.sv
// rtl/result_monitor.sv - samples the result stream, filters repeats, timestamps and queues captured words
module result_monitor
    import result_mon_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int TS_W   = DEF_TS_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   res_valid,
    input  logic [DATA_W-1:0]      res_data,
    input  logic                   filter_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [TS_W-1:0]        out_time,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [7:0]             drop_cnt,
    input  logic                   clear_ovf
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TS_W-1:0]   stamp;
    } mon_entry_t;

    logic [TS_W-1:0]   ts;
    logic [DATA_W-1:0] last_data;
    logic              last_vld;
    logic              filtered;
    logic              full;
    logic              pop;
    logic              push;
    logic              lost;
    mon_entry_t        push_item;
    mon_entry_t        head;

    assign out_valid = (level != '0);
    assign pop       = out_valid && out_ready;
    assign full      = (level == FULL_LEVEL);
    assign filtered  = filter_en && last_vld && (res_data == last_data);

    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push      = res_valid && !filtered && (!full || pop);
    assign lost      = res_valid && !filtered && full && !pop;
    assign push_item = '{data: res_data, stamp: ts};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts        <= '0;
            last_data <= '0;
            last_vld  <= 1'b0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            ts <= ts + 1'b1;
            if (push) begin
                last_data <= res_data;
                last_vld  <= 1'b1;
            end
            if (clear_ovf) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end else if (lost) begin
                overflow <= 1'b1;
                if (drop_cnt != DROP_MAX) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end

    result_fifo #(
        .DEPTH  (DEPTH),
        .item_t (mon_entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_item (push_item),
        .pop       (pop),
        .level     (level),
        .head      (head)
    );

    assign out_data = head.data;
    assign out_time = head.stamp;

endmodule

// File: tb/tb_result_monitor.sv
// tb/tb_result_monitor.sv - table-driven and scoreboard checks for result_monitor
module tb_result_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, res_valid, filter_en, out_valid, out_ready, overflow, clear_ovf;
    logic [31:0] res_data, out_data;
    logic [15:0] out_time;
    logic [3:0]  level;
    logic [7:0]  drop_cnt;

    result_monitor #(.DATA_W(32), .DEPTH(8), .TS_W(16)) dut (
        .clk(clk), .reset(reset), .res_valid(res_valid), .res_data(res_data),
        .filter_en(filter_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_time(out_time), .level(level),
        .overflow(overflow), .drop_cnt(drop_cnt), .clear_ovf(clear_ovf)
    );

    logic        reset4, rv4, ov4, overflow4;
    logic [31:0] rd4, od4;
    logic [3:0]  ot4, lvl4;
    logic [7:0]  dc4;

    result_monitor #(.DATA_W(32), .DEPTH(8), .TS_W(4)) dut4 (
        .clk(clk), .reset(reset4), .res_valid(rv4), .res_data(rd4),
        .filter_en(1'b0), .out_valid(ov4), .out_ready(1'b1),
        .out_data(od4), .out_time(ot4), .level(lvl4),
        .overflow(overflow4), .drop_cnt(dc4), .clear_ovf(1'b0)
    );

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        f;
        logic        r;
        logic        c;
        logic        cap;
        logic [3:0]  lvl;
        logic        ovf;
        logic [7:0]  drop;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [15:0] t;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        mon_en   = 1'b0;
    logic [15:0] tb_ts;
    logic [3:0]  wrap_exp[4];

    // Reference cycle count since reset release
    always @(posedge clk or negedge reset) begin
        if (!reset) tb_ts <= '0;
        else        tb_ts <= tb_ts + 16'd1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && out_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got data 0x%0h time %0d with nothing expected", out_data, out_time);
            end else begin
                check("out_data", out_data, sb[0].d);
                check("out_time", out_time, sb[0].t);
                if (out_ready) sb.delete(0);
            end
        end
    end

    function automatic vec_t mk(input logic v, input logic [31:0] d, input logic f, input logic r,
                                input logic c, input logic cap, input logic [3:0] lvl,
                                input logic ovf, input logic [7:0] drop);
        vec_t x;
        x.v = v; x.d = d; x.f = f; x.r = r; x.c = c; x.cap = cap;
        x.lvl = lvl; x.ovf = ovf; x.drop = drop;
        return x;
    endfunction

    task automatic step(input vec_t x, input int idx);
        exp_t e;
        res_valid = x.v; res_data = x.d; filter_en = x.f; out_ready = x.r; clear_ovf = x.c;
        if (x.v && x.cap) begin
            e.d = x.d;
            e.t = tb_ts;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        check($sformatf("level[%0d]", idx), level, x.lvl);
        check($sformatf("overflow[%0d]", idx), overflow, x.ovf);
        check($sformatf("drop_cnt[%0d]", idx), drop_cnt, x.drop);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Filter on: 5,5,5,7,5 keeps 5,7,5
        vecs.push_back(mk(1, 32'd5, 1, 1, 0, 1, 4'd1, 0, 8'd0));
        vecs.push_back(mk(1, 32'd5, 1, 1, 0, 0, 4'd0, 0, 8'd0));
        vecs.push_back(mk(1, 32'd5, 1, 1, 0, 0, 4'd0, 0, 8'd0));
        vecs.push_back(mk(1, 32'd7, 1, 1, 0, 1, 4'd1, 0, 8'd0));
        vecs.push_back(mk(1, 32'd5, 1, 1, 0, 1, 4'd1, 0, 8'd0));
        vecs.push_back(mk(0, 32'd0, 1, 1, 0, 0, 4'd0, 0, 8'd0));
        // Filter off: all five kept
        vecs.push_back(mk(1, 32'd5, 0, 1, 0, 1, 4'd1, 0, 8'd0));
        vecs.push_back(mk(1, 32'd5, 0, 1, 0, 1, 4'd1, 0, 8'd0));
        vecs.push_back(mk(1, 32'd5, 0, 1, 0, 1, 4'd1, 0, 8'd0));
        vecs.push_back(mk(1, 32'd7, 0, 1, 0, 1, 4'd1, 0, 8'd0));
        vecs.push_back(mk(1, 32'd5, 0, 1, 0, 1, 4'd1, 0, 8'd0));
        vecs.push_back(mk(0, 32'd0, 0, 1, 0, 0, 4'd0, 0, 8'd0));
        // Overflow: DEPTH+3 words with the reader stalled
        for (int i = 0; i < 11; i++)
            vecs.push_back(mk(1, 32'h100 + i, 0, 0, 0, i < 8, (i < 8) ? 4'(i + 1) : 4'd8,
                              i >= 8, (i >= 8) ? 8'(i - 7) : 8'd0));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 32'd0, 0, 1, 0, 0, 4'(7 - i), 1, 8'd3));
        vecs.push_back(mk(0, 32'd0, 0, 0, 1, 0, 4'd0, 0, 8'd0));
        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1, 32'h200 + i, 0, 0, 0, 1, 4'(i + 1), 0, 8'd0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 32'h208 + i, 0, 1, 0, 1, 4'd8, 0, 8'd0));
        // Clear wins over a loss in the same cycle
        vecs.push_back(mk(1, 32'h20C, 0, 0, 1, 0, 4'd8, 0, 8'd0));
        vecs.push_back(mk(1, 32'h20D, 0, 0, 0, 0, 4'd8, 1, 8'd1));
        vecs.push_back(mk(0, 32'd0, 0, 0, 1, 0, 4'd8, 0, 8'd0));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 32'd0, 0, 1, 0, 0, 4'(7 - i), 0, 8'd0));

        wrap_exp[0] = 4'd14; wrap_exp[1] = 4'd15; wrap_exp[2] = 4'd0; wrap_exp[3] = 4'd1;

        reset = 1'b0; res_valid = 1'b0; res_data = '0; filter_en = 1'b0;
        out_ready = 1'b0; clear_ovf = 1'b0;
        reset4 = 1'b0; rv4 = 1'b0; rd4 = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_time", out_time, 16'd0);
        check("rst_level", level, 4'd0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_drop_cnt", drop_cnt, 8'd0);

        // Basic capture at ts=3
        reset = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        res_valid = 1'b1; res_data = 32'h11; out_ready = 1'b1;
        sb.push_back('{32'h11, 16'd3});
        @(posedge clk);
        #1;
        res_valid = 1'b0;
        check("basic_out_valid", out_valid, 1'b1);
        check("basic_level", level, 4'd1);
        @(posedge clk);
        #1;
        check("basic_level_after", level, 4'd0);

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);
        check("sb_drained", sb.size(), 0);

        // Reset mid-stream with three entries queued
        step(mk(1, 32'h300, 0, 0, 0, 1, 4'd1, 0, 8'd0), 100);
        step(mk(1, 32'h301, 0, 0, 0, 1, 4'd2, 0, 8'd0), 101);
        step(mk(1, 32'h302, 0, 0, 0, 1, 4'd3, 0, 8'd0), 102);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_level", level, 4'd0);
        check("midrst_out_data", out_data, 32'd0);
        check("midrst_out_time", out_time, 16'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        step(mk(1, 32'h302, 1, 1, 0, 1, 4'd1, 0, 8'd0), 103);
        step(mk(0, 32'd0, 1, 1, 0, 0, 4'd0, 0, 8'd0), 104);
        check("sb_after_reset", sb.size(), 0);

        // Timestamp wrap on the 4-bit instance
        reset4 = 1'b1;
        repeat (14) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            rv4 = 1'b1;
            rd4 = 32'hA0 + i;
            @(posedge clk);
            #1;
            check($sformatf("wrap_valid[%0d]", i), ov4, 1'b1);
            check($sformatf("wrap_time[%0d]", i), ot4, wrap_exp[i]);
            check($sformatf("wrap_data[%0d]", i), od4, 32'hA0 + i);
        end
        rv4 = 1'b0;
        @(posedge clk);
        #1;
        check("wrap_level", lvl4, 4'd0);
        check("wrap_drop", dc4, 8'd0);
        check("wrap_ovf", overflow4, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/result_monitor.md
# result_monitor

Hardware counterpart of the bench-side result monitor. It samples the `pipeline_processor` result stream, drops repeated values when filtering is enabled, and timestamps each captured word with a free-running cycle counter. Captured entries sit in a small FIFO that a downstream reader (a debug port or bench) drains over a valid/ready interface. It sits beside the processor at the top level, on the consumer end of the result interface.

## Interface
Parameters:
- `DATA_W`, 32, result word width
- `DEPTH`, 8, FIFO entries; must be a power of 2, at least 2
- `TS_W`, 16, timestamp width

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset)
- `res_valid`  in  1  result word present this cycle
- `res_data`  in  DATA_W  result word from the processor
- `filter_en`  in  1  1 = drop a word equal to the last captured word
- `out_valid`  out  1  head entry available
- `out_ready`  in  1  reader accepts the head entry
- `out_data`  out  DATA_W  head entry data
- `out_time`  out  TS_W  head entry timestamp
- `level`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- `overflow`  out  1  sticky: at least one word lost because the FIFO was full
- `drop_cnt`  out  8  saturating count of words lost to a full FIFO
- `clear_ovf`  in  1  synchronous clear of `overflow` and `drop_cnt`

## Operation
- **Timestamp:** `ts` counts up by 1 every cycle after reset deasserts. The first cycle out of reset is 0. It wraps from 2^TS_W−1 to 0 with no flag.
- **Candidate word:** a cycle is a candidate when `res_valid`=1.
- **Filter:** a candidate is filtered when `filter_en`=1, `last_vld`=1 and `res_data`==`last_data`. A filtered word is discarded silently and does not count as a drop.
- **Capture:**
  - A candidate that is not filtered is pushed as {`res_data`, `ts`}.
  - `last_data` and `last_vld` update on every accepted push. A word lost to overflow does not update them.
- **Full:**
  - A push while `level`==DEPTH with no pop this cycle is lost.
  - The loss sets `overflow` and increments `drop_cnt`, which saturates at 255.
  - If a pop occurs in the same cycle, the push is accepted and `level` stays at DEPTH.
- **Pop:** a pop occurs when `out_valid` && `out_ready`. A pop with an empty FIFO cannot occur because `out_valid` is 0.
- **Simultaneous push and pop:** `level` is unchanged. An empty FIFO never bypasses; the word appears at the output on the next cycle.
- **`clear_ovf`:** clears both `overflow` and `drop_cnt`. If a loss happens in the same cycle, the clear wins and that loss is not counted.
- **Pointers:** read and write pointers are `$clog2(DEPTH)` bits and wrap naturally. Full and empty are derived from `level`.

## Timing
- **Reset values:**
  - `out_valid`=0, `out_data`=0, `out_time`=0
  - `level`=0, `overflow`=0, `drop_cnt`=0
  - `ts`=0, `last_vld`=0, `last_data`=0
- **Push latency:** a push accepted at edge N gives `out_valid`=1 from after edge N. The data is visible in cycle N+1.
- **Output timing:** `out_data` and `out_time` come from registered or array-read head storage, with no combinational path from `res_*`. `out_valid` is a function of `level` only.
- **Output stability:** the outputs must hold stable while `out_valid`=1 and `out_ready`=0.
- **Throughput:** one push and one pop per cycle sustained.
- **Mid-operation reset:** asserting `reset` empties the FIFO immediately and asynchronously, and all outputs go to their reset values. After deassertion, the first capture is stamped `ts`=0 (or the cycle count since deassertion).

## Structure
- **Shared package `result_mon_pkg`:**
  - default `DATA_W`, `DEPTH`, `TS_W`
  - the entry struct {data, time}
  - the `DROP_MAX`=255 constant
- **Sub-module `result_fifo`:** a synchronous FIFO carrying the entry type, with ports push/pop/level/head. It is a natural split from the top module.
- **Top module contents:** timestamp counter, filter registers, overflow/drop logic.
- **Expected size:** about 200 lines of RTL total.

## Test plan
- **Reset and basic capture:** reset low for 2 cycles, then `res_valid` for one cycle with 0x11 at `ts`=3 and `out_ready`=1. Expect `out_valid` one cycle later with `out_data`=0x11 and `out_time`=3, then `level` returns to 0.
- **Filter:** `filter_en`=1, drive 5,5,5,7,5 on consecutive cycles. Expect exactly 5,7,5 captured. Repeat with `filter_en`=0 and expect all 5 words captured.
- **Overflow:** `out_ready`=0, push DEPTH+3 distinct words. Expect `level`=DEPTH, `overflow`=1, `drop_cnt`=3, and the drained order is the first DEPTH words. Then pulse `clear_ovf` and expect `overflow`=0 and `drop_cnt`=0.
- **Full with simultaneous push and pop:** fill the FIFO, then drive `out_ready`=1 and `res_valid`=1 for 4 cycles. Expect no drops, `level`=DEPTH throughout, and FIFO ordering preserved.
- **Timestamp wrap:** with `TS_W`=4, capture at cycles 14, 15, 16 and 17. Expect `out_time` = 14, 15, 0, 1.
- **Reset mid-stream:** with 3 entries queued, assert `reset`. Expect `out_valid`=0 and `level`=0 immediately; after release, a capture works normally and the drop counter is 0.
